// File: rtl/disc_reader.sv
// disc_reader: drive acquisition engine.
// Synchronises the drive's read-data, index and track-mark lines, timestamps
// their edges with a 7-bit interval counter, queues the resulting codes in a
// small event FIFO and drains that FIFO one byte per cycle into the shared
// acquisition memory through a write-strobe / address-increment port.
module disc_reader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rddata,
  input  logic       index,
  input  logic       trkmark,
  input  logic       start,
  input  logic       abort,
  input  logic       start_on_index,
  input  logic [5:0] idx_count,
  input  logic       mem_full,
  output logic [7:0] mdat_out,
  output logic       mwrite,
  output logic       maddr_inc,
  output logic       running,
  output logic       overrun,
  output logic       memfull_stop
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P = AW'(1);

  localparam logic [7:0] CODE_OVF = 8'h7F;
  localparam logic [7:0] CODE_IDX = 8'h40;
  localparam logic [7:0] CODE_TRK = 8'h03;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_ACQ   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // Synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] r_rd_sync;
  logic [SYNC_STAGES-1:0] r_ix_sync;
  logic [SYNC_STAGES-1:0] r_tm_sync;
  logic                   r_rd_prev;
  logic                   r_ix_prev;
  logic                   r_tm_prev;
  logic                   w_rd_evt;
  logic                   w_ix_evt;
  logic                   w_tm_evt;

  // Control state
  state_t     r_state;
  state_t     w_state_nx;
  logic [5:0] r_idx_rem;
  logic [6:0] r_cnt;
  logic       w_load_start;
  logic       w_enter_acq;
  logic       w_capture;
  logic       w_ix_dec;
  logic       w_set_mfs;
  logic       w_clear;
  logic       w_pop;

  // Event FIFO
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Push arbitration (slot 0 = pulse/overflow, 1 = index, 2 = track mark)
  logic          w_cnt_wrap;
  logic [2:0]    w_pv;
  logic [7:0]    w_pd   [3];
  logic [2:0]    w_we;
  logic [AW-1:0] w_widx [3];
  logic [AW-1:0] w_off;
  logic [AW:0]   w_fill;
  logic          w_ovf;

  // Registered outputs
  logic [7:0] r_mdat;
  logic       r_mwrite;
  logic       r_running;
  logic       r_overrun;
  logic       r_memfull_stop;

  // Synchronise the drive inputs and keep one extra flop of history for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_sync <= '1;
      r_ix_sync <= '0;
      r_tm_sync <= '0;
      r_rd_prev <= 1'b1;
      r_ix_prev <= 1'b0;
      r_tm_prev <= 1'b0;
    end else begin
      r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], rddata};
      r_ix_sync <= {r_ix_sync[SYNC_STAGES-2:0], index};
      r_tm_sync <= {r_tm_sync[SYNC_STAGES-2:0], trkmark};
      r_rd_prev <= r_rd_sync[SYNC_STAGES-1];
      r_ix_prev <= r_ix_sync[SYNC_STAGES-1];
      r_tm_prev <= r_tm_sync[SYNC_STAGES-1];
    end
  end

  // Read data pulses are active-low, index and track mark active-high
  assign w_rd_evt = r_rd_prev & ~r_rd_sync[SYNC_STAGES-1];
  assign w_ix_evt = ~r_ix_prev & r_ix_sync[SYNC_STAGES-1];
  assign w_tm_evt = ~r_tm_prev & r_tm_sync[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic, capture enable and drain decision
  always_comb begin
    w_state_nx   = r_state;
    w_load_start = 1'b0;
    w_enter_acq  = 1'b0;
    w_capture    = 1'b0;
    w_ix_dec     = 1'b0;
    w_set_mfs    = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx   = S_ARM;
          w_load_start = 1'b1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_ARM: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_clear    = 1'b1;
        end else if (!start_on_index || w_ix_evt) begin
          // The arming index edge itself is neither recorded nor counted
          w_state_nx  = S_ACQ;
          w_enter_acq = 1'b1;
        end else begin
          w_state_nx = S_ARM;
        end
      end
      S_ACQ: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_clear    = 1'b1;
        end else if (mem_full) begin
          w_state_nx = S_IDLE;
          w_set_mfs  = 1'b1;
        end else begin
          w_capture = 1'b1;
          if (w_ix_evt && (r_idx_rem != 6'd0)) begin
            w_ix_dec = 1'b1;
            if (r_idx_rem == 6'd1) begin
              w_state_nx = S_DRAIN;
            end else begin
              w_state_nx = S_ACQ;
            end
          end else begin
            w_state_nx = S_ACQ;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_clear    = 1'b1;
        end else if (mem_full) begin
          w_state_nx = S_IDLE;
          w_set_mfs  = 1'b1;
        end else if (r_count == '0) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_DRAIN;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
    w_pop = ((r_state == S_ACQ) || (r_state == S_DRAIN)) && !abort && !mem_full
            && (r_count != '0);
  end

  // Build up to three codes per cycle and allocate FIFO slots in priority order
  always_comb begin
    w_cnt_wrap = (r_cnt == 7'd127);
    w_pv[0]    = w_capture & (w_rd_evt | w_cnt_wrap);
    w_pv[1]    = w_capture & w_ix_evt;
    w_pv[2]    = w_capture & w_tm_evt;
    w_pd[0]    = w_rd_evt ? {1'b1, r_cnt} : CODE_OVF;
    w_pd[1]    = CODE_IDX;
    w_pd[2]    = CODE_TRK;
    w_fill     = r_count;
    w_off      = '0;
    w_ovf      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_we[i]   = 1'b0;
      w_widx[i] = r_wptr + w_off;
      if (w_pv[i]) begin
        // Occupancy seen by a push is the start-of-cycle count plus earlier pushes
        if (w_fill < DEPTH_C) begin
          w_we[i] = 1'b1;
          w_fill  = w_fill + ONE_C;
          w_off   = w_off + ONE_P;
        end else begin
          w_ovf = 1'b1;
        end
      end else begin
        w_ovf = w_ovf;
      end
    end
  end

  // Interval counter: clocks since the previous pulse or overflow code
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 7'd0;
    end else if (w_enter_acq) begin
      r_cnt <= 7'd1;
    end else if (w_capture) begin
      if (w_rd_evt || w_cnt_wrap) begin
        r_cnt <= 7'd1;
      end else begin
        r_cnt <= r_cnt + 7'd1;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Remaining index edges before acquisition ends (zero = unlimited)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_idx_rem <= 6'd0;
    end else if (w_load_start) begin
      r_idx_rem <= idx_count;
    end else if (w_ix_dec) begin
      r_idx_rem <= r_idx_rem - 6'd1;
    end else begin
      r_idx_rem <= r_idx_rem;
    end
  end

  // FIFO pointers and occupancy; start and abort both discard the contents
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_load_start || w_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + w_off;
      r_rptr  <= r_rptr + {{(AW-1){1'b0}}, w_pop};
      r_count <= r_count + {1'b0, w_off} - {{AW{1'b0}}, w_pop};
    end
  end

  // FIFO storage; data only, so no reset is needed
  always_ff @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (w_we[i]) begin
        r_fifo[w_widx[i]] <= w_pd[i];
      end
    end
  end

  // Memory write port: one popped byte per strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mwrite <= 1'b0;
      r_mdat   <= 8'h00;
    end else begin
      r_mwrite <= w_pop;
      if (w_pop) begin
        r_mdat <= r_fifo[r_rptr];
      end else begin
        r_mdat <= r_mdat;
      end
    end
  end

  // Status: running mirrors the next state so it lines up with the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_running      <= 1'b0;
      r_overrun      <= 1'b0;
      r_memfull_stop <= 1'b0;
    end else begin
      r_running <= (w_state_nx != S_IDLE);
      if (w_load_start) begin
        r_overrun      <= 1'b0;
        r_memfull_stop <= 1'b0;
      end else begin
        r_overrun      <= r_overrun | w_ovf;
        r_memfull_stop <= r_memfull_stop | w_set_mfs;
      end
    end
  end

  assign mdat_out     = r_mdat;
  assign mwrite       = r_mwrite;
  assign maddr_inc    = r_mwrite;
  assign running      = r_running;
  assign overrun      = r_overrun;
  assign memfull_stop = r_memfull_stop;

endmodule

// File: tb/tb_disc_reader.sv
// Self-checking bench for disc_reader: reset values, a table of pulse gaps with
// their expected interval codes, a randomized pulse/track-mark stream checked
// against a timestamp-based reference model, and hand-written corner sequences.
module tb_disc_reader;

  localparam int MAXC = 16384;

  logic       clock = 1'b0;
  logic       reset;
  logic       rddata;
  logic       index;
  logic       trkmark;
  logic       start;
  logic       abort;
  logic       start_on_index;
  logic [5:0] idx_count;
  logic       mem_full;
  logic [7:0] mdat_out;
  logic       mwrite;
  logic       maddr_inc;
  logic       running;
  logic       overrun;
  logic       memfull_stop;

  disc_reader #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .rddata(rddata), .index(index), .trkmark(trkmark),
    .start(start), .abort(abort), .start_on_index(start_on_index), .idx_count(idx_count),
    .mem_full(mem_full), .mdat_out(mdat_out), .mwrite(mwrite), .maddr_inc(maddr_inc),
    .running(running), .overrun(overrun), .memfull_stop(memfull_stop)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    int         gap;
    int         n_exp;
    logic [7:0] e0;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  typedef struct {
    int         t;
    int         pri;
    logic [7:0] code;
  } ev_t;

  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         wcyc_q[$];
  ev_t        evq[$];
  bit         rd_low[MAXC];
  bit         ix_hi[MAXC];
  bit         tm_hi[MAXC];
  bit         ab_hi[MAXC];
  bit         run_hist[MAXC];

  always @(posedge clock) cyc <= cyc + 1;

  // Collect every written byte and check the address increment tracks the strobe
  always @(negedge clock) begin
    if (mwrite === 1'b1 || maddr_inc === 1'b1) begin
      n_vec++;
      if (mwrite !== maddr_inc) begin
        n_bad++;
        $display("FAIL maddr_inc: got %b required %b", maddr_inc, mwrite);
      end
    end
    if (mwrite === 1'b1) begin
      got_q.push_back(mdat_out);
      wcyc_q.push_back(cyc);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic pop_got(output logic [31:0] v);
    if (got_q.size() == 0) begin
      v = 32'hFFFF_FFFF;
    end else begin
      v = {24'h0, got_q.pop_front()};
    end
  endtask

  task automatic clear_sched();
    for (int i = 0; i < MAXC; i++) begin
      rd_low[i] = 1'b0;
      ix_hi[i]  = 1'b0;
      tm_hi[i]  = 1'b0;
      ab_hi[i]  = 1'b0;
    end
    got_q.delete();
    wcyc_q.delete();
  endtask

  // Called at a negedge; pin values for step c are applied at the c-th negedge
  task automatic run_sched(input int len);
    for (int c = 0; c < len; c++) begin
      run_hist[c] = running;
      rddata  = ~rd_low[c];
      index   = ix_hi[c];
      trkmark = tm_hi[c];
      abort   = ab_hi[c];
      @(negedge clock);
    end
    rddata  = 1'b1;
    index   = 1'b0;
    trkmark = 1'b0;
    abort   = 1'b0;
  endtask

  task automatic do_start(input bit soi, input logic [5:0] cnt);
    start          = 1'b1;
    start_on_index = soi;
    idx_count      = cnt;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    @(negedge clock);
  endtask

  // Reference model: insert an event keeping the list ordered by time, then priority
  task automatic add_ev(input int t, input int pri, input logic [7:0] code);
    int  pos;
    ev_t e;
    e   = '{t, pri, code};
    pos = evq.size();
    for (int i = 0; i < evq.size(); i++) begin
      if ((evq[i].t * 4 + evq[i].pri) > (t * 4 + pri)) begin
        pos = i;
        break;
      end
    end
    evq.insert(pos, e);
  endtask

  // A gap of g clocks is k = (g-1)/127 overflow codes then a pulse code of g - 127k
  task automatic add_gap(input int t_prev, input int t_now);
    int g;
    int k;
    g = t_now - t_prev;
    k = (g - 1) / 127;
    for (int j = 1; j <= k; j++) add_ev(t_prev + 127 * j, 0, 8'h7F);
    add_ev(t_now, 0, 8'h80 | 8'(g - 127 * k));
  endtask

  initial begin
    vec_t        vt[9];
    logic [31:0] v;
    logic [7:0]  e;
    int          t;
    int          p[25];
    int          tmt;

    reset = 1'b1; rddata = 1'b1; index = 1'b0; trkmark = 1'b0; start = 1'b0;
    abort = 1'b0; start_on_index = 1'b0; idx_count = 6'd0; mem_full = 1'b0;
    repeat (3) @(negedge clock);

    // ---------------- reset state ----------------
    check("rst_mdat", {24'h0, mdat_out}, 32'h00);
    check("rst_mwrite", {31'h0, mwrite}, 32'h0);
    check("rst_maddr_inc", {31'h0, maddr_inc}, 32'h0);
    check("rst_running", {31'h0, running}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_memfull_stop", {31'h0, memfull_stop}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // ---------------- table of pulse gaps ----------------
    vt[0] = '{"gap50",  50,  1, 8'hB2, 8'h00, 8'h00};
    vt[1] = '{"gap30",  30,  1, 8'h9E, 8'h00, 8'h00};
    vt[2] = '{"gap127", 127, 1, 8'hFF, 8'h00, 8'h00};
    vt[3] = '{"gap300", 300, 3, 8'h7F, 8'h7F, 8'hAE};
    vt[4] = '{"gap128", 128, 2, 8'h7F, 8'h81, 8'h00};
    vt[5] = '{"gap2",   2,   1, 8'h82, 8'h00, 8'h00};
    vt[6] = '{"gap254", 254, 2, 8'h7F, 8'hFF, 8'h00};
    vt[7] = '{"gap255", 255, 3, 8'h7F, 8'h7F, 8'h81};
    vt[8] = '{"gap126", 126, 1, 8'hFE, 8'h00, 8'h00};
    clear_sched();
    t = 5;
    rd_low[t] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      t = t + vt[i].gap;
      rd_low[t] = 1'b1;
    end
    do_start(1'b0, 6'd0);
    run_sched(t + 12);
    do_abort();
    check("tbl_running_after_abort", {31'h0, running}, 32'h0);
    pop_got(v);
    check("tbl_first_code", v, 32'h87);
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < vt[i].n_exp; j++) begin
        e = (j == 0) ? vt[i].e0 : ((j == 1) ? vt[i].e1 : vt[i].e2);
        pop_got(v);
        check(vt[i].name, v, {24'h0, e});
      end
    end
    check("tbl_extra_writes", got_q.size(), 32'd0);

    // ---------------- randomized pulses and track marks ----------------
    clear_sched();
    evq.delete();
    p[0] = 5 + $urandom_range(0, 20);
    rd_low[p[0]] = 1'b1;
    for (int i = 1; i < 25; i++) begin
      p[i] = p[i-1] + $urandom_range(2, 400);
      rd_low[p[i]] = 1'b1;
      add_gap(p[i-1], p[i]);
    end
    for (int k = 0; k < 20; k++) begin
      tmt = p[0] + 1 + $urandom_range(0, p[24] - p[0] - 1);
      if (!tm_hi[tmt-1] && !tm_hi[tmt] && !tm_hi[tmt+1]) begin
        tm_hi[tmt] = 1'b1;
        add_ev(tmt, 2, 8'h03);
      end
    end
    do_start(1'b0, 6'd0);
    run_sched(p[24] + 12);
    do_abort();
    pop_got(v);
    check("rnd_first_code", v, {24'h0, 8'h80 | 8'(p[0] + 2)});
    for (int i = 0; i < evq.size(); i++) begin
      pop_got(v);
      check("rnd_code", v, {24'h0, evq[i].code});
    end
    check("rnd_extra_writes", got_q.size(), 32'd0);
    check("rnd_overrun", {31'h0, overrun}, 32'h0);

    // ---------------- pulse, index and track mark in one cycle ----------------
    clear_sched();
    rd_low[5] = 1'b1; ix_hi[5] = 1'b1; tm_hi[5] = 1'b1;
    do_start(1'b0, 6'd0);
    run_sched(20);
    do_abort();
    check("same_cycle_count", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      check("same_cycle_pulse", {24'h0, got_q[0]}, 32'h87);
      check("same_cycle_index", {24'h0, got_q[1]}, 32'h40);
      check("same_cycle_trk", {24'h0, got_q[2]}, 32'h03);
      check("same_cycle_spacing1", wcyc_q[1] - wcyc_q[0], 32'd1);
      check("same_cycle_spacing2", wcyc_q[2] - wcyc_q[1], 32'd1);
    end
    check("same_cycle_overrun", {31'h0, overrun}, 32'h0);

    // ---------------- start on index, two counted index edges ----------------
    clear_sched();
    rd_low[4] = 1'b1;
    ix_hi[10] = 1'b1;
    rd_low[20] = 1'b1; rd_low[30] = 1'b1;
    ix_hi[40] = 1'b1;
    rd_low[50] = 1'b1;
    ix_hi[60] = 1'b1;
    rd_low[70] = 1'b1; rd_low[80] = 1'b1;
    do_start(1'b1, 6'd2);
    run_sched(100);
    check("idx_running_in_arm", {31'h0, run_hist[5]}, 32'h1);
    check("idx_running_end", {31'h0, running}, 32'h0);
    check("idx_count", got_q.size(), 32'd5);
    pop_got(v); check("idx_b0", v, 32'h8A);
    pop_got(v); check("idx_b1", v, 32'h8A);
    pop_got(v); check("idx_b2", v, 32'h40);
    pop_got(v); check("idx_b3", v, 32'h94);
    pop_got(v); check("idx_b4", v, 32'h40);

    // ---------------- mem_full held for the whole run ----------------
    clear_sched();
    mem_full = 1'b1;
    rd_low[5] = 1'b1; ix_hi[5] = 1'b1; tm_hi[7] = 1'b1; rd_low[8] = 1'b1; tm_hi[9] = 1'b1;
    do_start(1'b0, 6'd0);
    run_sched(30);
    check("mf_writes", got_q.size(), 32'd0);
    check("mf_memfull_stop", {31'h0, memfull_stop}, 32'h1);
    check("mf_running", {31'h0, running}, 32'h0);
    check("mf_overrun", {31'h0, overrun}, 32'h0);
    mem_full = 1'b0;
    do_start(1'b0, 6'd0);
    check("mf_cleared_on_start", {31'h0, memfull_stop}, 32'h0);
    do_abort();

    // ---------------- FIFO overrun from back-to-back bursts ----------------
    clear_sched();
    for (int k = 5; k <= 9; k += 2) begin
      rd_low[k] = 1'b1; ix_hi[k] = 1'b1; tm_hi[k] = 1'b1;
    end
    do_start(1'b0, 6'd0);
    run_sched(30);
    check("ovr_overrun", {31'h0, overrun}, 32'h1);
    if (got_q.size() >= 3) begin
      check("ovr_kept0", {24'h0, got_q[0]}, 32'h87);
      check("ovr_kept1", {24'h0, got_q[1]}, 32'h40);
      check("ovr_kept2", {24'h0, got_q[2]}, 32'h03);
    end else begin
      check("ovr_min_writes", got_q.size(), 32'd3);
    end
    do_abort();
    do_start(1'b0, 6'd0);
    check("ovr_cleared_on_start", {31'h0, overrun}, 32'h0);
    do_abort();

    // ---------------- abort with the FIFO non-empty ----------------
    clear_sched();
    rd_low[5] = 1'b1; ix_hi[5] = 1'b1; tm_hi[5] = 1'b1;
    ab_hi[9] = 1'b1;
    do_start(1'b0, 6'd0);
    run_sched(30);
    check("abort_running_before", {31'h0, run_hist[9]}, 32'h1);
    check("abort_running_after", {31'h0, run_hist[10]}, 32'h0);
    check("abort_writes", got_q.size(), 32'd1);

    // ---------------- asynchronous reset during a write strobe ----------------
    clear_sched();
    rd_low[5] = 1'b1; ix_hi[5] = 1'b1; tm_hi[5] = 1'b1;
    do_start(1'b0, 6'd0);
    run_sched(9);
    check("pre_reset_mwrite", {31'h0, mwrite}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_mwrite", {31'h0, mwrite}, 32'h0);
    check("arst_maddr_inc", {31'h0, maddr_inc}, 32'h0);
    check("arst_mdat", {24'h0, mdat_out}, 32'h00);
    check("arst_running", {31'h0, running}, 32'h0);
    check("arst_overrun", {31'h0, overrun}, 32'h0);
    check("arst_memfull_stop", {31'h0, memfull_stop}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_reset_running", {31'h0, running}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/disc_reader.md
Name: disc_reader

Overview:
- Acquisition engine. Timestamps read-data pulses, index pulses and hard-sector track marks from the drive.
- Emits a byte stream of interval and marker codes into the shared acquisition memory through a write-strobe/address-increment port.
- Sits beside the disc writer on the same memory bus and drive inputs. Started and stopped by the control register block.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, minimum 4.
- SYNC_STAGES, 2, synchroniser flops on each of rddata, index and trkmark; minimum 2.

Ports:
- clock  in  1  master clock
- reset  in  1  asynchronous, active-high reset
- rddata  in  1  drive read data, active-low pulses
- index  in  1  index pulse, active-high
- trkmark  in  1  hard-sector track mark detect, active-high
- start  in  1  begin acquisition; sampled only in IDLE
- abort  in  1  stop acquisition immediately; FIFO is discarded
- start_on_index  in  1  when 1, ARM waits for an index edge before capturing
- idx_count  in  6  number of index edges to capture; 0 means unlimited. Latched on start.
- mem_full  in  1  memory address at top; no further writes accepted
- mdat_out  out  8  byte to write
- mwrite  out  1  one-cycle write strobe; memory writes mdat_out at the current address
- maddr_inc  out  1  asserted in the same cycle as mwrite; memory address advances after the write
- running  out  1  high whenever state != IDLE
- overrun  out  1  sticky flag: event lost because the FIFO was full; cleared on start
- memfull_stop  out  1  sticky flag: acquisition ended by mem_full; cleared on start

Behaviour:
- Reset (async): state=IDLE; mdat_out=0x00; mwrite=0; maddr_inc=0; overrun=0; memfull_stop=0; FIFO empty; counter=0; synchronisers=0 for index/trkmark and 1 for rddata.
- Edge detect on the synchronised signals:
  - rddata: falling edge (1->0) = pulse event.
  - index, trkmark: rising edge (0->1).
  - Pin-to-event latency: SYNC_STAGES+1 cycles.
- Output codes:
  - 1nnn_nnnn: data pulse, n = clocks since previous reference (0..127).
  - 0x7F: interval overflow, 127 clocks with no pulse.
  - 0x40: index mark.
  - 0x03: track mark.
- Interval counter (7-bit):
  - Loaded with 1 on the ACQ entry cycle.
  - Each ACQ cycle: if pulse event, push {1,counter} and counter<=1; else if counter==127, push 0x7F and counter<=1; else counter<=counter+1.
  - Pulse and overflow in the same cycle: pulse wins (0xFF); no 0x7F is pushed.
  - Total elapsed clocks = 127 x (count of 0x7F codes) + n.
- Same-cycle push order: pulse/overflow code first, then index mark, then track mark. Up to 3 pushes per cycle.
- FIFO overflow:
  - Any push that finds the FIFO full is dropped and sets overrun.
  - Codes already pushed earlier in the same cycle are kept.
- Drain: when the FIFO is non-empty, state is ACQ or DRAIN, and mem_full=0, pop one entry per cycle. In that cycle mdat_out=entry, mwrite=1, maddr_inc=1.
- States:
  - IDLE: outputs quiescent. start=1 -> latch idx_count into idx_rem, clear FIFO, clear flags, go to ARM.
  - ARM: if start_on_index=0, go to ACQ next cycle. Otherwise wait for an index edge, then go to ACQ.
    - The arming edge is not recorded and does not decrement idx_rem.
  - ACQ: capture and drain as above.
    - On each index edge with idx_rem!=0: decrement idx_rem.
    - If idx_rem transitions to 0: the 0x40 for that edge is still pushed, then go to DRAIN.
    - If idx_rem==0 at start: unlimited capture.
  - DRAIN: capture disabled. Empty the FIFO, then go to IDLE.
- Stop conditions:
  - abort=1 in any non-IDLE state -> IDLE next cycle; FIFO cleared; no further mwrite.
  - mem_full=1 in ACQ or DRAIN -> no mwrite that cycle; set memfull_stop; go to IDLE.
  - abort and mem_full in the same cycle: abort wins; memfull_stop is not set.
- Reset mid-acquisition: immediate return to the reset state. No partial write strobe may be emitted.

Test Plan:
- start_on_index=0, idx_count=0; rddata falling edges 50 then 30 clocks apart -> after the first-edge code, bytes 0xB2 then 0x9E written, one mwrite per byte.
- Pulse gap of 300 clocks -> 0x7F, 0x7F, 0xAE (127+127+46) in order; gap of exactly 127 -> single 0xFF, no 0x7F.
- start_on_index=1, idx_count=2; 3 index edges with pulses between -> capture begins after edge 1 (not recorded), 0x40 written for edges 2 and 3, DRAIN empties FIFO, running falls, later pulses are not written.
- Pulse, index and trkmark edges in the same cycle, FIFO empty -> writes 0x80|n, 0x40, 0x03 in that order on consecutive cycles; overrun stays 0.
- Hold mem_full=1 while 5 events arrive with FIFO_DEPTH=4 -> no mwrite, memfull_stop=1, state returns to IDLE; a repeat run with drain stalled and 5 events queued sets overrun.
- abort asserted in ACQ with FIFO non-empty -> running=0 next cycle, no further mwrite; reset asserted mid-run -> all outputs at reset values asynchronously.
